// File: rtl/switch_input_unit_pkg.sv
// Shared FSM encoding and debounce default for the switch input path.
// Imported by the control unit and the switch input unit.
package switch_input_unit_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    DONE         = 2'd3
  } siu_state_t;

endpackage

// File: rtl/debouncer.sv
// Debounces an already-synchronized level.
// rise pulses for one cycle on each accepted 0->1 change.
module debouncer
  import switch_input_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic db,
  output logic rise
);

  localparam int CNT_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             db_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      db   <= 1'b0;
      db_q <= 1'b0;
    end else begin
      db_q <= db;
      if (din == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        db  <= din;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = db & ~db_q;

endmodule

// File: rtl/switch_input_unit.sv
// Captures the board switch word for an IN instruction on a
// debounced enter press, stalling the PC until the button is released.
module switch_input_unit
  import switch_input_unit_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_raw,
  input  logic              btn_enter_raw,
  input  logic              in_request,
  output logic [DATA_W-1:0] switches,
  output logic              stall,
  output logic              in_ready
);

  logic [DATA_W-1:0] sw_s1;
  logic [DATA_W-1:0] sw_s2;
  logic              btn_s1;
  logic              btn_s2;
  logic              btn_db;
  logic              press_pulse;
  logic [1:0]        sync_vld;
  logic              armed;
  siu_state_t        state;
  siu_state_t        state_n;
  logic              capture;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_enter_raw;
      btn_s2 <= btn_s1;
    end
  end

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock(clock),
    .reset(reset),
    .din  (btn_s2),
    .db   (btn_db),
    .rise (press_pulse)
  );

  // A press counts only once the button was seen released after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_vld <= 2'b00;
      armed    <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && !btn_s2 && !btn_db)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_request) state_n = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!in_request) begin
          state_n = IDLE;
        end else if (press_pulse && armed) begin
          state_n = WAIT_RELEASE;
          capture = 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!in_request)  state_n = IDLE;
        else if (!btn_db) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        switches <= '0;
    else if (capture) switches <= sw_s2;
  end

  assign stall    = in_request && (state != DONE);
  assign in_ready = (state == DONE);

endmodule

// File: tb/tb_switch_input_unit.sv
// Bench for switch_input_unit with DEBOUNCE_CYCLES=4.
// Cycle model of the specified behaviour runs alongside the DUT.
module tb_switch_input_unit;

  localparam int DW = 16;
  localparam int DB = 4;

  localparam int M_IDLE = 0;
  localparam int M_WP   = 1;
  localparam int M_WR   = 2;
  localparam int M_DONE = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] sw_raw = '0;
  logic          btn_enter_raw = 1'b0;
  logic          in_request = 1'b0;
  logic [DW-1:0] switches;
  logic          stall;
  logic          in_ready;

  int checks = 0;
  int failures = 0;

  switch_input_unit #(
    .DATA_W(DW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_raw(sw_raw),
    .btn_enter_raw(btn_enter_raw),
    .in_request(in_request),
    .switches(switches),
    .stall(stall),
    .in_ready(in_ready)
  );

  always #5 clock = ~clock;

  // reference model state
  bit          m_b1, m_b2;
  bit [DW-1:0] m_w1, m_w2;
  bit          m_db, m_db_prev, m_armed;
  int          m_run, m_warm, m_st;
  bit [DW-1:0] m_sw;

  function automatic void model_reset();
    m_b1 = 0; m_b2 = 0; m_w1 = '0; m_w2 = '0;
    m_db = 0; m_db_prev = 0; m_armed = 0;
    m_run = 0; m_warm = 0; m_st = M_IDLE; m_sw = '0;
  endfunction

  function automatic void model_step();
    bit press;
    int st_n;
    bit [DW-1:0] sw_n;
    bit db_n;
    bit armed_n;
    press = m_db && !m_db_prev;
    st_n = m_st;
    sw_n = m_sw;
    if (m_st == M_IDLE) begin
      if (in_request) st_n = M_WP;
    end else if (m_st == M_WP) begin
      if (!in_request) st_n = M_IDLE;
      else if (press && m_armed) begin
        st_n = M_WR;
        sw_n = m_w2;
      end
    end else if (m_st == M_WR) begin
      if (!in_request) st_n = M_IDLE;
      else if (!m_db) st_n = M_DONE;
    end else begin
      st_n = M_IDLE;
    end
    armed_n = m_armed || (m_warm >= 2 && !m_b2 && !m_db);
    db_n = m_db;
    if (m_b2 == m_db) m_run = 0;
    else if (m_run == DB - 1) begin
      db_n = m_b2;
      m_run = 0;
    end else m_run++;
    m_db_prev = m_db;
    m_db = db_n;
    m_armed = armed_n;
    m_warm = (m_warm < 2) ? m_warm + 1 : 2;
    m_st = st_n;
    m_sw = sw_n;
    m_b2 = m_b1; m_b1 = btn_enter_raw;
    m_w2 = m_w1; m_w1 = sw_raw;
  endfunction

  function automatic logic [DW+1:0] expv();
    return {m_sw, in_request && (m_st != M_DONE), m_st == M_DONE};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset) model_reset();
    else model_step();
    #1;
  endtask

  task automatic idle_n(input int n);
    repeat (n) tick();
  endtask

  task automatic do_in(input logic [DW-1:0] v);
    sw_raw = v;
    in_request = 1;
    idle_n(3);
    btn_enter_raw = 1;
    idle_n(10);
    btn_enter_raw = 0;
    idle_n(10);
    in_request = 0;
    idle_n(2);
  endtask

  task automatic test_reset();
    in_request = 1;
    sw_raw = 16'h5555;
    reset = 1;
    model_reset();
    #1;
    checks++;
    if ({switches, stall, in_ready} !== {16'h0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_async got=%h/%b/%b exp=0000/1/0",
               switches, stall, in_ready);
    end
    idle_n(2);
    in_request = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall_follow got=%b exp=0", stall);
    end
    reset = 0;
    idle_n(3);
    checks++;
    if ({switches, stall, in_ready} !== expv()) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h",
               {switches, stall, in_ready}, expv());
    end
  endtask

  task automatic test_reset_mid_capture();
    do_in(16'h1234);
    checks++;
    if (switches !== 16'h1234) begin
      failures++;
      $display("FAIL capture_1234 got=%h exp=1234", switches);
    end
    in_request = 1;
    idle_n(3);
    btn_enter_raw = 1;
    idle_n(3);
    reset = 1;
    model_reset();
    #1;
    checks++;
    if ({switches, stall, in_ready} !== {16'h0000, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got=%h/%b/%b exp=0000/1/0",
               switches, stall, in_ready);
    end
    idle_n(2);
    reset = 0;
    btn_enter_raw = 0;
    in_request = 0;
    idle_n(8);
    checks++;
    if ({switches, stall, in_ready} !== {16'h0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_discard got=%h/%b/%b exp=0000/0/0",
               switches, stall, in_ready);
    end
  endtask

  task automatic test_clean_press();
    int pulses;
    sw_raw = 16'hBEEF;
    idle_n(3);
    in_request = 1;
    btn_enter_raw = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++;
      if ({switches, stall} !== {(i >= 7) ? 16'hBEEF : 16'h0000, 1'b1}) begin
        failures++;
        $display("FAIL clean_latency cyc=%0d got=%h/%b", i, switches, stall);
      end
    end
    btn_enter_raw = 0;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({switches, stall, in_ready} !== expv()) begin
        failures++;
        $display("FAIL clean_release cyc=%0d got=%h exp=%h",
                 i, {switches, stall, in_ready}, expv());
      end
      if (in_ready === 1'b1) begin
        pulses++;
        checks++;
        if (stall !== 1'b0) begin
          failures++;
          $display("FAIL clean_stall_done got=%b exp=0", stall);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL clean_ready_pulses got=%0d exp=1", pulses);
    end
    in_request = 0;
    idle_n(2);
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    int pulses;
    int caps;
    logic [DW-1:0] last;
    pat = 4'b1010;
    sw_raw = 16'hA5A5;
    in_request = 1;
    idle_n(3);
    for (int i = 3; i >= 0; i--) begin
      btn_enter_raw = pat[i];
      tick();
      checks++;
      if (switches !== 16'hBEEF) begin
        failures++;
        $display("FAIL bounce_hold got=%h exp=beef", switches);
      end
    end
    pulses = 0;
    caps = 0;
    last = switches;
    for (int i = 0; i < 28; i++) begin
      btn_enter_raw = (i < 14);
      tick();
      if (in_ready === 1'b1) pulses++;
      if (switches !== last) caps++;
      last = switches;
      checks++;
      if ({switches, stall, in_ready} !== expv()) begin
        failures++;
        $display("FAIL bounce_model cyc=%0d got=%h exp=%h",
                 i, {switches, stall, in_ready}, expv());
      end
    end
    checks++;
    if (pulses != 1 || caps != 1 || switches !== 16'hA5A5) begin
      failures++;
      $display("FAIL bounce_once got=%0d/%0d/%h exp=1/1/a5a5",
               pulses, caps, switches);
    end
    in_request = 0;
    idle_n(2);
  endtask

  task automatic test_held_before_request();
    int pulses;
    sw_raw = 16'h3C3C;
    btn_enter_raw = 1;
    idle_n(12);
    in_request = 1;
    pulses = 0;
    repeat (12) begin
      tick();
      if (in_ready === 1'b1) pulses++;
    end
    checks++;
    if (switches !== 16'hA5A5 || pulses != 0) begin
      failures++;
      $display("FAIL held_no_capture got=%h/%0d exp=a5a5/0", switches, pulses);
    end
    btn_enter_raw = 0;
    idle_n(8);
    btn_enter_raw = 1;
    idle_n(10);
    checks++;
    if (switches !== 16'h3C3C) begin
      failures++;
      $display("FAIL repress_capture got=%h exp=3c3c", switches);
    end
    btn_enter_raw = 0;
    pulses = 0;
    repeat (12) begin
      tick();
      if (in_ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL repress_ready got=%0d exp=1", pulses);
    end
    in_request = 0;
    idle_n(2);
  endtask

  task automatic test_drop_request();
    int pulses;
    do_in(16'h00FF);
    sw_raw = 16'h7777;
    in_request = 1;
    idle_n(3);
    in_request = 0;
    tick();
    checks++;
    if ({switches, stall, in_ready} !== {16'h00FF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL drop_idle got=%h/%b/%b exp=00ff/0/0",
               switches, stall, in_ready);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      btn_enter_raw = (i < 10);
      tick();
      if (in_ready === 1'b1) pulses++;
    end
    checks++;
    if (switches !== 16'h00FF || pulses != 0) begin
      failures++;
      $display("FAIL drop_no_ready got=%h/%0d exp=00ff/0", switches, pulses);
    end
  endtask

  task automatic test_sw_change();
    int pulses;
    sw_raw = 16'h0001;
    in_request = 1;
    idle_n(3);
    btn_enter_raw = 1;
    idle_n(8);
    checks++;
    if (switches !== 16'h0001) begin
      failures++;
      $display("FAIL swchg_capture got=%h exp=0001", switches);
    end
    sw_raw = 16'h0002;
    idle_n(6);
    checks++;
    if ({switches, in_ready} !== {16'h0001, 1'b0}) begin
      failures++;
      $display("FAIL swchg_hold got=%h/%b exp=0001/0", switches, in_ready);
    end
    btn_enter_raw = 0;
    pulses = 0;
    repeat (10) begin
      tick();
      if (in_ready === 1'b1) pulses++;
    end
    checks++;
    if (switches !== 16'h0001 || pulses != 1) begin
      failures++;
      $display("FAIL swchg_done got=%h/%0d exp=0001/1", switches, pulses);
    end
    in_request = 0;
    idle_n(2);
  endtask

  task automatic test_reset_held();
    int pulses;
    sw_raw = 16'h4242;
    btn_enter_raw = 1;
    reset = 1;
    model_reset();
    idle_n(2);
    in_request = 1;
    reset = 0;
    pulses = 0;
    repeat (15) begin
      tick();
      if (in_ready === 1'b1) pulses++;
    end
    checks++;
    if (switches !== 16'h0000 || pulses != 0) begin
      failures++;
      $display("FAIL reset_held got=%h/%0d exp=0000/0", switches, pulses);
    end
    btn_enter_raw = 0;
    idle_n(8);
    btn_enter_raw = 1;
    idle_n(10);
    checks++;
    if (switches !== 16'h4242) begin
      failures++;
      $display("FAIL reset_held_repress got=%h exp=4242", switches);
    end
    btn_enter_raw = 0;
    idle_n(10);
    in_request = 0;
    idle_n(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) btn_enter_raw = ~btn_enter_raw;
      if ($urandom_range(0, 24) == 0) in_request = ~in_request;
      if ($urandom_range(0, 7) == 0) sw_raw = DW'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        reset = 1;
        model_reset();
        tick();
        reset = 0;
      end
      tick();
      checks++;
      if ({switches, stall, in_ready} !== expv()) begin
        failures++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 i, {switches, stall, in_ready}, expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_mid_capture();
    test_clean_press();
    test_bounce();
    test_held_before_request();
    test_drop_request();
    test_sw_change();
    test_reset_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
